sd_sched: RTL and testbench
===========================

Name: sd_sched

Overview:
- Scheduler in front of the synaptic-dendrite (sd) datapath. Accepts axon events through a valid/ready stream and issues them to sd's read-modify-write membrane accumulator.
- Inserts bubbles for back-to-back read-after-write hazards on the same membrane address.
- On each timestep tick: drains the event pipe, pulses the ping-pong bank swap, then sweeps every neuron address so sd delivers accumulated Vm to soma and clears it.

Parameters:
- NNW, 12, neuron-number/Vm address width
- WD, 6, weight address width
- LAN_num, 2, lane bits per event
- CNTW, 32, perf counter width (only used with SD_SCHED_PERF_EN)

Ports:
- clk_SD  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ev_vld  in  1  axon event valid
- ev_rdy  out  1  event accepted when ev_vld&ev_rdy
- ev_vm_addr  in  NNW  target neuron
- ev_wgt_addr  in  WD  weight index
- ev_lans  in  LAN_num  lane bits
- tick_req  in  1  single-cycle timestep request
- neuron_last  in  NNW  last neuron index to sweep; sampled at SWAP
- clear_en  in  1  clear Vm during sweep; sampled at SWAP
- tick_busy  out  1  high from tick accept until done
- tick_done  out  1  one-cycle pulse at sweep end
- axon_sd_vld  out  1  event issue to sd
- axon_sd_vm_addr  out  NNW  issued neuron address
- axon_sd_wgt_addr  out  WD  issued weight address
- axon_sd_lans  out  LAN_num  issued lanes
- config_sd_start  out  1  bank swap pulse
- config_sd_vld  out  1  sweep read/clear strobe
- config_sd_vm_addr  out  NNW  sweep address
- config_sd_clear  out  1  clear qualifier (= config_sd_vld & latched clear_en)
- soma_vld  out  1  sd_soma_vm valid this cycle (config_sd_vld delayed 1)
- soma_addr  out  NNW  neuron index for soma_vld

Behaviour:
- Reset: all outputs 0, FSM = RUN, ev_rdy = 0 during reset. rst_n is asynchronous, active-low; clock is clk_SD.
- States: RUN, DRAIN, SWAP, SWEEP, DONE.
- RUN, issue path:
  - Accepted event is registered onto axon_sd_* the next cycle (latency 1). axon_sd_vld is high exactly one cycle per event.
  - ev_rdy = (state==RUN) & !hazard & !tick_pend.
  - hazard = axon_sd_vld & (ev_vm_addr == axon_sd_vm_addr). Gives exactly one bubble cycle; different addresses issue back-to-back at 1/cycle.
- tick_req:
  - Sets tick_pend, which is held until SWAP.
  - Events offered in the same cycle as tick_req are not accepted; they belong to the next timestep.
  - RUN->DRAIN when tick_pend.
  - tick_req while tick_busy is ignored.
- DRAIN: waits until axon_sd_vld==0 and its 1-cycle write-back delay has passed (2 cycles after the last issue), then ->SWAP.
- SWAP: config_sd_start=1 for one cycle. Latches neuron_last and clear_en. Sweep address counter reset to 0. ->SWEEP.
- SWEEP:
  - config_sd_vld=1 each cycle; config_sd_vm_addr = counter 0..neuron_last, incrementing by 1.
  - config_sd_clear = latched clear_en.
  - At counter==neuron_last ->DONE. No wrap; neuron_last=0 gives a single-cycle sweep.
- DONE: tick_done=1 for one cycle; ->RUN. tick_busy is 0 from the next cycle.
- soma_vld/soma_addr are registered copies of config_sd_vld/config_sd_vm_addr, matching sd's 1-cycle read latency.
- Reset mid-sweep: FSM and counters return to RUN immediately, outputs 0, no tick_done; bank select inside sd is not restored by this block.

Optional Feature:
- Macro: SD_SCHED_PERF_EN.
- Defined: adds outputs perf_ev_cnt[CNTW-1:0] (accepted events) and perf_stall_cnt[CNTW-1:0] (cycles with ev_vld & !ev_rdy in RUN).
  - Both saturate at all-ones.
  - Both snapshot into registered outputs at tick_done, then the live counters clear.
- Undefined: ports and logic absent; remaining behaviour identical.

Decomposition:
- Package sd_pkg: FSM state enum (RUN/DRAIN/SWAP/SWEEP/DONE); event struct {vm_addr, wgt_addr, lans}; NNW/WD/LAN_num defaults.
- One natural sub-module: sd_sweep_cnt (load/enable counter with last-index compare and done flag), reusable for other per-neuron sweeps.

Test Plan:
- Events to addr 5,7,9 on consecutive cycles -> axon_sd_vld high 3 consecutive cycles, addresses 5,7,9, no bubble.
- Events addr 5 then 5 -> ev_rdy low one cycle; issues at t+1 and t+3; sd Vm[5] = w0+w1.
- tick_req with neuron_last=3, clear_en=1, one in-flight event -> DRAIN 2 cycles, config_sd_start pulse, config_sd_vld 4 cycles at addresses 0..3 with clear=1, soma_vld 1 cycle later, tick_done one cycle after last sweep cycle.
- tick_req with ev_vld held high -> event not accepted until the cycle after tick_done; it is issued in the new bank.
- rst_n asserted mid-SWEEP at addr 2 -> outputs 0 asynchronously; after release FSM in RUN, ev_rdy=1, no tick_done.
- With SD_SCHED_PERF_EN: 10 events, 3 hazard stalls, then tick -> perf_ev_cnt=10, perf_stall_cnt=3 after tick_done; live counters restart from 0.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared types for the synaptic-dendrite scheduler.
//   - sd_state_t : scheduler FSM states (RUN/DRAIN/SWAP/SWEEP/DONE)
//   - sd_event_t : axon event at the default widths
//   - *_DEF      : default widths for NNW / WD / LAN_num / CNTW
package sd_pkg;

    localparam int unsigned NNW_DEF  = 12;
    localparam int unsigned WD_DEF   = 6;
    localparam int unsigned LAN_DEF  = 2;
    localparam int unsigned CNTW_DEF = 32;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        SWAP,
        SWEEP,
        DONE
    } sd_state_t;

    typedef struct packed {
        logic [NNW_DEF-1:0] vm_addr;
        logic [WD_DEF-1:0]  wgt_addr;
        logic [LAN_DEF-1:0] lans;
    } sd_event_t;

endpackage

// File: rtl/sd_sweep_cnt.sv
// sd_sweep_cnt: per-neuron sweep address counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart at 0 and capture 'last' as the final index
//   last       : final index to visit (inclusive)
//   en         : advance one index; holds at the final index (no wrap)
//   cnt        : current index
//   at_last    : cnt equals the captured final index
//   done       : set once the final index has been visited with en high;
//                cleared by load or reset
module sd_sweep_cnt #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] last,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_last,
    output logic         done
);

    logic [W-1:0] last_q;

    assign at_last = (cnt == last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            last_q <= '0;
            done   <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            last_q <= last;
            done   <= 1'b0;
        end else if (en) begin
            if (at_last) begin
                done <= 1'b1;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/sd_sched.sv
// sd_sched: event scheduler in front of the sd membrane accumulator.
// Issues accepted axon events to sd (one-cycle latency), inserts a bubble
// for a back-to-back event to the same membrane address, and on a timestep
// tick drains the pipe, pulses the bank swap and sweeps neurons 0..last.
//
// Ports:
//   clk_SD, rst_n           clock, asynchronous active-low reset
//   ev_vld/ev_rdy           event stream handshake
//   ev_vm_addr/wgt_addr/lans event fields
//   tick_req                single-cycle timestep request
//   neuron_last, clear_en   sweep range and clear qualifier (captured at SWAP)
//   tick_busy, tick_done    timestep in progress / end-of-sweep pulse
//   axon_sd_*               event issue to sd
//   config_sd_start         bank swap pulse
//   config_sd_vld/vm_addr   sweep strobe and address
//   config_sd_clear         clear qualifier for the sweep strobe
//   soma_vld, soma_addr     sweep strobe delayed by sd's read latency
//   perf_ev_cnt, perf_stall_cnt  (only with SD_SCHED_PERF_EN) snapshot of
//                           accepted events / RUN stall cycles at tick_done
//
// Optional feature macro: SD_SCHED_PERF_EN
module sd_sched
    import sd_pkg::*;
#(
    parameter int unsigned NNW     = NNW_DEF,
    parameter int unsigned WD      = WD_DEF,
    parameter int unsigned LAN_num = LAN_DEF
`ifdef SD_SCHED_PERF_EN
    ,
    parameter int unsigned CNTW    = CNTW_DEF
`endif
) (
    input  logic               clk_SD,
    input  logic               rst_n,
    input  logic               ev_vld,
    output logic               ev_rdy,
    input  logic [NNW-1:0]     ev_vm_addr,
    input  logic [WD-1:0]      ev_wgt_addr,
    input  logic [LAN_num-1:0] ev_lans,
    input  logic               tick_req,
    input  logic [NNW-1:0]     neuron_last,
    input  logic               clear_en,
    output logic               tick_busy,
    output logic               tick_done,
    output logic               axon_sd_vld,
    output logic [NNW-1:0]     axon_sd_vm_addr,
    output logic [WD-1:0]      axon_sd_wgt_addr,
    output logic [LAN_num-1:0] axon_sd_lans,
    output logic               config_sd_start,
    output logic               config_sd_vld,
    output logic [NNW-1:0]     config_sd_vm_addr,
    output logic               config_sd_clear,
    output logic               soma_vld,
    output logic [NNW-1:0]     soma_addr
`ifdef SD_SCHED_PERF_EN
    ,
    output logic [CNTW-1:0]    perf_ev_cnt,
    output logic [CNTW-1:0]    perf_stall_cnt
`endif
);

    // Same layout as sd_event_t, but at this instance's widths.
    typedef struct packed {
        logic [NNW-1:0]     vm_addr;
        logic [WD-1:0]      wgt_addr;
        logic [LAN_num-1:0] lans;
    } ev_t;

    sd_state_t    state, state_nxt;
    ev_t          ev_in, iss_q;
    logic         rdy_en;
    logic         tick_pend;
    logic         wb_vld;
    logic         clear_lat;
    logic         hazard;
    logic         accept;
    logic         tick_acc;
    logic         sweep_load;
    logic         sweep_en;
    logic         sweep_last;
    logic         sweep_done;
    logic [NNW-1:0] sweep_cnt;

    assign ev_in = '{vm_addr: ev_vm_addr, wgt_addr: ev_wgt_addr, lans: ev_lans};

    // Read-after-write on the same membrane word: hold off one cycle.
    assign hazard    = axon_sd_vld && (ev_vm_addr == axon_sd_vm_addr);
    assign tick_busy = tick_pend || (state != RUN);
    assign tick_acc  = tick_req && !tick_busy;
    // rdy_en keeps ev_rdy low while reset is held; an event offered with
    // tick_req belongs to the next timestep, so tick_req also blocks it.
    assign ev_rdy = rdy_en && (state == RUN) && !hazard && !tick_pend && !tick_req;
    assign accept = ev_vld && ev_rdy;

    assign axon_sd_vm_addr  = iss_q.vm_addr;
    assign axon_sd_wgt_addr = iss_q.wgt_addr;
    assign axon_sd_lans     = iss_q.lans;

    assign config_sd_vm_addr = config_sd_vld ? sweep_cnt : '0;
    assign config_sd_clear   = config_sd_vld && clear_lat;

    always_ff @(posedge clk_SD or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            rdy_en      <= 1'b0;
            tick_pend   <= 1'b0;
            axon_sd_vld <= 1'b0;
            iss_q       <= '0;
            wb_vld      <= 1'b0;
            clear_lat   <= 1'b0;
            soma_vld    <= 1'b0;
            soma_addr   <= '0;
        end else begin
            state       <= state_nxt;
            rdy_en      <= 1'b1;
            axon_sd_vld <= accept;
            if (accept) begin
                iss_q <= ev_in;
            end
            // sd writes back one cycle after an issue.
            wb_vld <= axon_sd_vld;
            if (state == SWAP) begin
                tick_pend <= 1'b0;
                clear_lat <= clear_en;
            end else if (tick_acc) begin
                tick_pend <= 1'b1;
            end
            soma_vld  <= config_sd_vld;
            soma_addr <= config_sd_vm_addr;
        end
    end

    always_comb begin
        state_nxt       = state;
        config_sd_start = 1'b0;
        config_sd_vld   = 1'b0;
        tick_done       = 1'b0;
        sweep_load      = 1'b0;
        sweep_en        = 1'b0;
        case (state)
            RUN: begin
                if (tick_pend) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!axon_sd_vld && !wb_vld) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                config_sd_start = 1'b1;
                sweep_load      = 1'b1;
                state_nxt       = SWEEP;
            end
            SWEEP: begin
                config_sd_vld = 1'b1;
                sweep_en      = 1'b1;
                if (sweep_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                tick_done = sweep_done;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    sd_sweep_cnt #(
        .W (NNW)
    ) u_sweep (
        .clk     (clk_SD),
        .rst_n   (rst_n),
        .load    (sweep_load),
        .last    (neuron_last),
        .en      (sweep_en),
        .cnt     (sweep_cnt),
        .at_last (sweep_last),
        .done    (sweep_done)
    );

`ifdef SD_SCHED_PERF_EN
    logic [CNTW-1:0] ev_live;
    logic [CNTW-1:0] stall_live;
    logic            stall;

    assign stall = (state == RUN) && ev_vld && !ev_rdy;

    always_ff @(posedge clk_SD or negedge rst_n) begin
        if (!rst_n) begin
            ev_live        <= '0;
            stall_live     <= '0;
            perf_ev_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else if (tick_done) begin
            // No accept or stall can occur in DONE, so nothing is lost here.
            perf_ev_cnt    <= ev_live;
            perf_stall_cnt <= stall_live;
            ev_live        <= '0;
            stall_live     <= '0;
        end else begin
            if (accept && (ev_live != '1)) begin
                ev_live <= ev_live + CNTW'(1);
            end
            if (stall && (stall_live != '1)) begin
                stall_live <= stall_live + CNTW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sd_sched.sv
// tb_sd_sched: directed self-checking bench for sd_sched.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after the edge. A small Vm array stands in for sd.
// Define SD_SCHED_PERF_EN to also exercise the perf counters.
module tb_sd_sched;

    localparam int unsigned NNW     = 12;
    localparam int unsigned WD      = 6;
    localparam int unsigned LAN_num = 2;

    logic               clk_SD = 1'b0;
    logic               rst_n;
    logic               ev_vld;
    logic               ev_rdy;
    logic [NNW-1:0]     ev_vm_addr;
    logic [WD-1:0]      ev_wgt_addr;
    logic [LAN_num-1:0] ev_lans;
    logic               tick_req;
    logic [NNW-1:0]     neuron_last;
    logic               clear_en;
    logic               tick_busy;
    logic               tick_done;
    logic               axon_sd_vld;
    logic [NNW-1:0]     axon_sd_vm_addr;
    logic [WD-1:0]      axon_sd_wgt_addr;
    logic [LAN_num-1:0] axon_sd_lans;
    logic               config_sd_start;
    logic               config_sd_vld;
    logic [NNW-1:0]     config_sd_vm_addr;
    logic               config_sd_clear;
    logic               soma_vld;
    logic [NNW-1:0]     soma_addr;
`ifdef SD_SCHED_PERF_EN
    logic [31:0]        perf_ev_cnt;
    logic [31:0]        perf_stall_cnt;
`endif

    always #5 clk_SD = ~clk_SD;

    sd_sched #(
        .NNW     (NNW),
        .WD      (WD),
        .LAN_num (LAN_num)
    ) dut (
        .clk_SD            (clk_SD),
        .rst_n             (rst_n),
        .ev_vld            (ev_vld),
        .ev_rdy            (ev_rdy),
        .ev_vm_addr        (ev_vm_addr),
        .ev_wgt_addr       (ev_wgt_addr),
        .ev_lans           (ev_lans),
        .tick_req          (tick_req),
        .neuron_last       (neuron_last),
        .clear_en          (clear_en),
        .tick_busy         (tick_busy),
        .tick_done         (tick_done),
        .axon_sd_vld       (axon_sd_vld),
        .axon_sd_vm_addr   (axon_sd_vm_addr),
        .axon_sd_wgt_addr  (axon_sd_wgt_addr),
        .axon_sd_lans      (axon_sd_lans),
        .config_sd_start   (config_sd_start),
        .config_sd_vld     (config_sd_vld),
        .config_sd_vm_addr (config_sd_vm_addr),
        .config_sd_clear   (config_sd_clear),
        .soma_vld          (soma_vld),
        .soma_addr         (soma_addr)
`ifdef SD_SCHED_PERF_EN
        ,
        .perf_ev_cnt       (perf_ev_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    // Stand-in for sd's membrane array (low 4 address bits are enough here).
    logic [15:0] vm [16];
    always @(posedge clk_SD or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) vm[i] <= '0;
        end else begin
            if (axon_sd_vld)
                vm[axon_sd_vm_addr[3:0]] <= vm[axon_sd_vm_addr[3:0]] + 16'(axon_sd_wgt_addr);
            if (config_sd_clear)
                vm[config_sd_vm_addr[3:0]] <= '0;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_SD);
        #1;
    endtask

    task automatic drive(input logic v, input int unsigned a, input int unsigned w);
        ev_vld      = v;
        ev_vm_addr  = NNW'(a);
        ev_wgt_addr = WD'(w);
        ev_lans     = LAN_num'(w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int unsigned got_done, starts, sweeps, early, dones;
`ifdef SD_SCHED_PERF_EN
    int unsigned pa [10] = '{1, 1, 2, 3, 3, 4, 5, 5, 6, 7};
    int unsigned idx;
`endif

    initial begin
        rst_n       = 1'b0;
        tick_req    = 1'b0;
        neuron_last = '0;
        clear_en    = 1'b0;
        drive(1'b1, 3, 1);
        #2;
        check("rst ev_rdy", ev_rdy, 0);
        check("rst axon_vld", axon_sd_vld, 0);
        check("rst busy", tick_busy, 0);
        check("rst start", config_sd_start, 0);
        check("rst sweep_vld", config_sd_vld, 0);
        check("rst done", tick_done, 0);
        repeat (2) @(posedge clk_SD);
        @(negedge clk_SD);
        rst_n = 1'b1;
        drive(1'b0, 0, 0);
        cyc();
        #1 check("post-rst ev_rdy", ev_rdy, 1);

        // Back-to-back events to distinct addresses: no bubble.
        cyc(); drive(1'b1, 5, 1);
        #1 check("b2b rdy0", ev_rdy, 1);
        cyc(); drive(1'b1, 7, 2);
        #1 check("b2b vld0", axon_sd_vld, 1); check("b2b addr0", axon_sd_vm_addr, 5);
        check("b2b rdy1", ev_rdy, 1);
        cyc(); drive(1'b1, 9, 3);
        #1 check("b2b vld1", axon_sd_vld, 1); check("b2b addr1", axon_sd_vm_addr, 7);
        check("b2b rdy2", ev_rdy, 1);
        cyc(); drive(1'b0, 0, 0);
        #1 check("b2b vld2", axon_sd_vld, 1); check("b2b addr2", axon_sd_vm_addr, 9);
        check("b2b wgt2", axon_sd_wgt_addr, 3); check("b2b lans2", axon_sd_lans, 3);
        cyc();
        #1 check("b2b idle", axon_sd_vld, 0);

        // Same address twice: one bubble.
        cyc(); drive(1'b1, 5, 3);
        #1 check("haz rdy0", ev_rdy, 1);
        cyc(); drive(1'b1, 5, 4);
        #1 check("haz rdy bubble", ev_rdy, 0); check("haz vld0", axon_sd_vld, 1);
        check("haz wgt0", axon_sd_wgt_addr, 3);
        cyc();
        #1 check("haz rdy1", ev_rdy, 1); check("haz gap", axon_sd_vld, 0);
        cyc(); drive(1'b0, 0, 0);
        #1 check("haz vld1", axon_sd_vld, 1); check("haz wgt1", axon_sd_wgt_addr, 4);
        cyc();
        #1 check("haz vm5", vm[5], 8);   // 1 + 3 + 4

        // Tick with one in-flight event, sweep 0..3 with clear.
        cyc(); drive(1'b1, 2, 5);
        #1 check("tk rdy", ev_rdy, 1);
        cyc(); drive(1'b0, 0, 0); tick_req = 1'b1; neuron_last = 3; clear_en = 1'b1;
        #1 check("tk inflight", axon_sd_vld, 1); check("tk busy0", tick_busy, 0);
        check("tk rdy w/ tick", ev_rdy, 0);
        cyc(); tick_req = 1'b0;
        #1 check("tk busy1", tick_busy, 1); check("tk start early0", config_sd_start, 0);
        cyc();
        #1 check("tk start early1", config_sd_start, 0);
        cyc();
        #1 check("tk start", config_sd_start, 1); check("tk swap sweep_vld", config_sd_vld, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) begin
                neuron_last = 7;
                clear_en    = 1'b0;
            end
            #1;
            check($sformatf("sw vld%0d", i), config_sd_vld, 1);
            check($sformatf("sw addr%0d", i), config_sd_vm_addr, i);
            check($sformatf("sw clr%0d", i), config_sd_clear, 1);
            check($sformatf("sw soma_vld%0d", i), soma_vld, (i > 0) ? 1 : 0);
            if (i > 0) check($sformatf("sw soma_addr%0d", i), soma_addr, i - 1);
            check($sformatf("sw done%0d", i), tick_done, 0);
        end
        cyc();
        #1 check("tk done", tick_done, 1); check("tk done sweep_vld", config_sd_vld, 0);
        check("tk soma last", soma_vld, 1); check("tk soma addr last", soma_addr, 3);
        check("tk busy done", tick_busy, 1);
        cyc();
        #1 check("tk done off", tick_done, 0); check("tk busy off", tick_busy, 0);
        check("tk soma off", soma_vld, 0); check("tk rdy back", ev_rdy, 1);
        check("tk vm2 cleared", vm[2], 0); check("tk vm5 kept", vm[5], 8);

        // Tick with an event held: accepted only after tick_done.
        cyc(); drive(1'b1, 10, 6); tick_req = 1'b1; neuron_last = 0; clear_en = 1'b0;
        #1 check("hold rdy at tick", ev_rdy, 0);
        got_done = 0; starts = 0; sweeps = 0; early = 0;
        for (int k = 0; k < 40 && got_done == 0; k++) begin
            cyc();
            tick_req = (k == 0);  // second request while busy must be ignored
            #1;
            if (ev_rdy) early++;
            starts += config_sd_start;
            sweeps += config_sd_vld;
            if (tick_done) got_done = 1;
        end
        tick_req = 1'b0;
        check("hold done seen", got_done, 1);
        check("hold starts", starts, 1);
        check("hold sweep len", sweeps, 1);
        check("hold early accept", early, 0);
        cyc();
        #1 check("hold rdy after", ev_rdy, 1);
        cyc(); drive(1'b0, 0, 0);
        #1 check("hold issue vld", axon_sd_vld, 1); check("hold issue addr", axon_sd_vm_addr, 10);
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            #1 starts += config_sd_start;
        end
        check("busy tick ignored", starts, 0);

        // Reset in the middle of a sweep.
        cyc(); tick_req = 1'b1; neuron_last = 5; clear_en = 1'b1;
        cyc(); tick_req = 1'b0;
        got_done = 0;
        for (int k = 0; k < 40 && got_done == 0; k++) begin
            cyc();
            #1;
            if (config_sd_vld && config_sd_vm_addr == 2) got_done = 1;
        end
        check("mid reach addr2", got_done, 1);
        rst_n = 1'b0;
        #1;
        check("mid sweep_vld", config_sd_vld, 0);
        check("mid sweep_addr", config_sd_vm_addr, 0);
        check("mid clear", config_sd_clear, 0);
        check("mid busy", tick_busy, 0);
        check("mid soma", soma_vld, 0);
        check("mid ev_rdy", ev_rdy, 0);
        @(negedge clk_SD);
        rst_n = 1'b1;
        dones = 0; sweeps = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            #1;
            dones  += tick_done;
            sweeps += config_sd_vld;
        end
        check("mid no done", dones, 0);
        check("mid no sweep", sweeps, 0);
        check("mid rdy", ev_rdy, 1);

`ifdef SD_SCHED_PERF_EN
        // 10 events with three same-address pairs, then a tick.
        idx = 0;
        for (int k = 0; k < 40 && idx < 10; k++) begin
            cyc(); drive(1'b1, pa[idx], 1);
            #1;
            if (ev_rdy) idx++;
        end
        check("perf all sent", idx, 10);
        cyc(); drive(1'b0, 0, 0); tick_req = 1'b1; neuron_last = 1;
        cyc(); tick_req = 1'b0;
        got_done = 0;
        for (int k = 0; k < 40 && got_done == 0; k++) begin
            cyc();
            #1 if (tick_done) got_done = 1;
        end
        check("perf done1", got_done, 1);
        cyc();
        #1 check("perf ev", perf_ev_cnt, 10); check("perf stall", perf_stall_cnt, 3);
        tick_req = 1'b1;
        cyc(); tick_req = 1'b0;
        got_done = 0;
        for (int k = 0; k < 40 && got_done == 0; k++) begin
            cyc();
            #1 if (tick_done) got_done = 1;
        end
        check("perf done2", got_done, 1);
        cyc();
        #1 check("perf ev restart", perf_ev_cnt, 0); check("perf stall restart", perf_stall_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
